// File: rtl/kernel_stream_feeder.sv
// Streams len words from a 1-cycle-latency synchronous memory onto a valid/ready port.
// A 2-entry FIFO with credit-based read issue sustains one word per cycle.
module kernel_stream_feeder #(
    parameter int STREAMW = 32,
    parameter int ADDRW   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDRW:0]     len,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDRW-1:0]   mem_addr,
    input  logic [STREAMW-1:0] mem_rdata,
    output logic               ovalid,
    input  logic               oready,
    output logic [STREAMW-1:0] odata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ZERO  = 2'd3;

    localparam logic [ADDRW:0] CNT_ONE = {{ADDRW{1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [ADDRW:0]     len_r;
    logic [ADDRW:0]     rd_cnt;
    logic [ADDRW:0]     out_cnt;
    logic               inflight;
    logic [1:0]         fifo_cnt;
    logic [STREAMW-1:0] tail;
    logic               push;
    logic               pop;
    logic [2:0]         occ;

    assign push     = inflight;
    assign pop      = ovalid & oready;
    assign ovalid   = (fifo_cnt != 2'd0);
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign mem_addr = rd_cnt[ADDRW-1:0];

    // Occupancy after this cycle's pop: stored words plus the read already in flight.
    assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en = (state == S_RUN) && (rd_cnt < len_r) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_r    <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            fifo_cnt <= '0;
            tail     <= '0;
            odata    <= '0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= mem_rd_en;
            if (mem_rd_en) rd_cnt <= rd_cnt + CNT_ONE;
            if (pop)       out_cnt <= out_cnt + CNT_ONE;

            // odata is the FIFO head register; tail only holds the second entry.
            if (push && !pop) begin
                if (fifo_cnt == 2'd0) odata <= mem_rdata;
                else                  tail  <= mem_rdata;
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (!push && pop) begin
                odata    <= tail;
                fifo_cnt <= fifo_cnt - 2'd1;
            end else if (push && pop) begin
                if (fifo_cnt == 2'd1) begin
                    odata <= mem_rdata;
                end else begin
                    odata <= tail;
                    tail  <= mem_rdata;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r   <= len;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        if (len == '0) begin
                            state <= S_ZERO;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (mem_rd_en && (rd_cnt + CNT_ONE == len_r)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && (out_cnt + CNT_ONE == len_r)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_stream_feeder.sv
// Scoreboard bench for kernel_stream_feeder: stimulus queues expected words,
// a negedge monitor checks handshakes, read addresses, credit bound and done timing.
module tb_kernel_stream_feeder;

    localparam int W  = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata = '0;
    logic          ovalid;
    logic          oready = 1'b0;
    logic [W-1:0]  odata;

    kernel_stream_feeder #(.STREAMW(W), .ADDRW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ovalid(ovalid), .oready(oready), .odata(odata)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [1024];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           exp_len = 0;
    bit           start_acc = 0;
    int           mode = 0;
    int           rd_issued = 0, pops = 0, start_cyc = 0, first_valid_cyc = 0;
    int           done_cyc = 0, done_cnt = 0, last_pop_cyc = 0;
    bit           first_seen = 0, hold_prev = 0;
    logic [W-1:0] odata_prev = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // oready pattern generator
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       oready = 1'b1;
            1:       oready = ~oready;
            2:       oready = 1'($urandom_range(0, 1));
            default: oready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            rd_issued = 0;
            pops      = 0;
            hold_prev = 0;
        end else begin
            if (start && start_acc) begin
                rd_issued  = 0;
                pops       = 0;
                start_cyc  = cyc;
                first_seen = 0;
            end
            if (hold_prev) begin
                chk("hold_valid", ovalid, 1);
                chk("hold_data", odata, odata_prev);
            end
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, rd_issued % 1024);
                rd_issued++;
                chk("rd_bound", rd_issued <= exp_len, 1);
            end
            if (ovalid && !first_seen) begin
                first_seen      = 1;
                first_valid_cyc = cyc;
            end
            if (ovalid && oready) begin
                if (exp_q.size() == 0) chk("unexpected_word", odata, 64'hdead_beef_dead_beef);
                else                   chk("odata", odata, exp_q.pop_front());
                pops++;
                last_pop_cyc = cyc;
            end
            chk("occupancy", (rd_issued - pops) <= 2, 1);
            if (busy) chk("zero_len_busy", exp_len != 0, 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_q_empty", exp_q.size(), 0);
                chk("done_reads", rd_issued, exp_len);
                chk("done_busy", busy, 0);
                if (exp_len != 0) chk("done_after_pop", cyc - last_pop_cyc, 1);
            end
            hold_prev  = ovalid && !oready;
            odata_prev = odata;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int l);
        start     = 1'b1;
        len       = (AW + 1)'(l);
        start_acc = 1'b1;
        exp_len   = l;
        for (int i = 0; i < l; i++) exp_q.push_back(mem[i]);
        tick(1);
        start     = 1'b0;
        start_acc = 1'b0;
        chk("busy_after_start", busy, l != 0);
    endtask

    task automatic wait_done(input int max);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < max) begin
            tick(1);
            n++;
        end
        chk("done_timeout", done_cnt != base, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odata", odata, 0);
    endtask

    initial begin
        int base, n, l;
        rst = 1'b1; start = 1'b0; len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = W'(i + 'h100);
        tick(2);
        chk_reset_outputs();
        rst = 1'b0;
        tick(1);

        // Full-rate run: latency and done timing
        do_start(8);
        wait_done(40);
        chk("lat_first_valid", first_valid_cyc - start_cyc, 3);
        chk("lat_done", done_cyc - start_cyc, 11);
        tick(2);

        // Alternating backpressure
        mode = 1;
        do_start(8);
        wait_done(60);
        mode = 0;
        tick(2);

        // Zero-length transfer
        base = done_cnt;
        do_start(0);
        wait_done(5);
        chk("zero_done_lat", done_cyc - start_cyc, 1);
        tick(3);
        chk("zero_done_once", done_cnt, base + 1);

        // Maximum length, no address wrap
        base = done_cnt;
        do_start(1024);
        wait_done(1100);
        chk("big_pops", pops, 1024);
        tick(3);
        chk("big_done_once", done_cnt, base + 1);

        // Long stall: only two reads may be outstanding
        mode = 3;
        do_start(4);
        tick(22);
        chk("stall_reads", rd_issued, 2);
        chk("stall_ovalid", ovalid, 1);
        chk("stall_odata", odata, 'h100);
        mode = 0;
        wait_done(30);
        tick(2);

        // Reset mid-transfer, then a fresh run
        base = done_cnt;
        do_start(8);
        n = 0;
        while (pops < 3 && n < 30) begin
            tick(1);
            n++;
        end
        chk("mid_reset_reach", pops >= 3, 1);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        chk_reset_outputs();
        tick(2);
        chk("mid_reset_no_done", done_cnt, base);
        do_start(2);
        wait_done(20);
        chk("post_reset_pops", pops, 2);
        tick(2);

        // Randomized data, lengths, backpressure and ignored starts while busy
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int r = 0; r < 6; r++) begin
            mode = 2;
            l = $urandom_range(1, 40);
            base = done_cnt;
            do_start(l);
            n = 0;
            while (done_cnt == base && n < 400) begin
                if (busy && $urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    len   = (AW + 1)'($urandom_range(0, 1024));
                end
                tick(1);
                start = 1'b0;
                n++;
            end
            chk("rand_done", done_cnt != base, 1);
            chk("rand_pops", pops, l);
            mode = 0;
            tick(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
